// File: rtl/noc_arb_pkg.sv
// -----------------------------------------------------------------------------
// noc_arb_pkg
// Shared types and helpers for the NoC round-robin output-port arbiter.
//   arb_state_e    : arbiter FSM states (idle / grant held)
//   idx_w()        : grant-index width for a given requester count, never 0
//   onehot_to_idx(): one-hot to binary encoder, sized for up to 16 requesters
// -----------------------------------------------------------------------------
package noc_arb_pkg;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_e;

    localparam int ARB_MAX_N = 16;

    // A single requester still needs a 1-bit index port.
    function automatic int idx_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Input is assumed one-hot (or zero); OR-ing the indices of set bits
    // yields the binary index and 0 for an all-zero vector.
    function automatic logic [3:0] onehot_to_idx(input logic [ARB_MAX_N-1:0] oh);
        logic [3:0] idx;
        idx = '0;
        for (int i = 0; i < ARB_MAX_N; i++) begin
            if (oh[i]) begin
                idx = idx | 4'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/noc_rr_arbiter_if.sv
// -----------------------------------------------------------------------------
// noc_rr_arbiter_if
// Request/grant bundle between N requesters and the output-port arbiter.
//   i_request[N]   : per-requester packet pending
//   i_last[N]      : per-requester current flit is the packet tail
//   i_ack          : downstream accepted the granted flit this cycle
//   o_grant[N]     : registered one-hot grant
//   o_grant_idx    : registered binary index of o_grant
//   o_busy         : registered, high while a grant is held
// Modports: master = requester/downstream side, slave = arbiter side.
// -----------------------------------------------------------------------------
interface noc_rr_arbiter_if
    import noc_arb_pkg::*;
#(
    parameter int N = 5
) ();

    localparam int IDX_W = idx_w(N);

    logic [N-1:0]     i_request;
    logic [N-1:0]     i_last;
    logic             i_ack;
    logic [N-1:0]     o_grant;
    logic [IDX_W-1:0] o_grant_idx;
    logic             o_busy;

    modport master (
        output i_request,
        output i_last,
        output i_ack,
        input  o_grant,
        input  o_grant_idx,
        input  o_busy
    );

    modport slave (
        input  i_request,
        input  i_last,
        input  i_ack,
        output o_grant,
        output o_grant_idx,
        output o_busy
    );

endinterface

// File: rtl/noc_prio_onehot.sv
// -----------------------------------------------------------------------------
// noc_prio_onehot
// Combinational lowest-index-first priority picker.
//   req[WIDTH]   : candidate vector
//   grant[WIDTH] : one-hot of the lowest set bit of req, all-zero if req is 0
// -----------------------------------------------------------------------------
module noc_prio_onehot #(
    parameter int WIDTH = 5
) (
    input  logic [WIDTH-1:0] req,
    output logic [WIDTH-1:0] grant
);

    // Two's-complement trick: req & -req isolates the lowest set bit.
    assign grant = req & (~req + WIDTH'(1));

endmodule

// File: rtl/noc_rr_arbiter.sv
// -----------------------------------------------------------------------------
// noc_rr_arbiter
// Packet-locked round-robin arbiter for one NoC router output port.
// A winner keeps the grant until its tail flit is acked; in that same cycle
// the next winner is chosen so consecutive packets flow without a bubble.
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   bus    : noc_rr_arbiter_if slave modport (requests in, grant out)
// All outputs come straight from flops; inputs feed next-state logic only.
// -----------------------------------------------------------------------------
module noc_rr_arbiter
    import noc_arb_pkg::*;
#(
    parameter  int N     = 5,
    localparam int IDX_W = idx_w(N)
) (
    input  logic               clk,
    input  logic               rst_n,
    noc_rr_arbiter_if.slave    bus
);

    arb_state_e       state_q, state_d;
    logic [N-1:0]     grant_q, grant_d;
    logic [IDX_W-1:0] grant_idx_q, grant_idx_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic             busy_q, busy_d;

    logic [N-1:0]     prio_mask;
    logic [N-1:0]     masked_req;
    logic [N-1:0]     win_masked;
    logic [N-1:0]     win_plain;
    logic [N-1:0]     winner;
    logic [IDX_W-1:0] winner_idx;
    logic             any_req;
    logic             tail_acked;

    // Requesters strictly above the last winner get first pick.
    always_comb begin
        prio_mask = '0;
        for (int i = 0; i < N; i++) begin
            if (i > int'(ptr_q)) begin
                prio_mask[i] = 1'b1;
            end
        end
    end

    assign masked_req = bus.i_request & prio_mask;
    assign any_req    = |bus.i_request;

    noc_prio_onehot #(.WIDTH(N)) u_pick_masked (
        .req   (masked_req),
        .grant (win_masked)
    );

    noc_prio_onehot #(.WIDTH(N)) u_pick_plain (
        .req   (bus.i_request),
        .grant (win_plain)
    );

    // Fall back to the unmasked pick when nobody above the pointer asks;
    // this is the wrap-around and is also how the previous winner can win
    // again, but only when it is the sole requester.
    assign winner     = (|masked_req) ? win_masked : win_plain;
    assign winner_idx = IDX_W'(onehot_to_idx(ARB_MAX_N'(winner)));

    // The grant vector is one-hot, so masking i_last with it selects the
    // granted requester's tail bit; other requesters' i_last is ignored.
    assign tail_acked = bus.i_ack && (|(bus.i_last & grant_q));

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        grant_idx_d = grant_idx_q;
        ptr_d       = ptr_q;
        busy_d      = busy_q;

        unique case (state_q)
            ARB_IDLE: begin
                if (any_req) begin
                    grant_d     = winner;
                    grant_idx_d = winner_idx;
                    ptr_d       = winner_idx;
                    busy_d      = 1'b1;
                    state_d     = ARB_BUSY;
                end
            end

            ARB_BUSY: begin
                // A granted requester dropping its request early does not
                // release the grant; only an acked tail does.
                if (tail_acked) begin
                    if (any_req) begin
                        grant_d     = winner;
                        grant_idx_d = winner_idx;
                        ptr_d       = winner_idx;
                        busy_d      = 1'b1;
                        state_d     = ARB_BUSY;
                    end else begin
                        grant_d     = '0;
                        grant_idx_d = '0;
                        busy_d      = 1'b0;
                        state_d     = ARB_IDLE;
                    end
                end
            end

            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ARB_IDLE;
            grant_q     <= '0;
            grant_idx_q <= '0;
            ptr_q       <= IDX_W'(N - 1);
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            grant_idx_q <= grant_idx_d;
            ptr_q       <= ptr_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.o_grant     = grant_q;
    assign bus.o_grant_idx = grant_idx_q;
    assign bus.o_busy      = busy_q;

endmodule

// File: doc/noc_rr_arbiter.md
# noc_rr_arbiter

Packet-locked round-robin arbiter sharing one NoC router output port among N input requesters. Picks one winner with a lowest-index-first one-hot priority picker over a rotating mask. Holds the grant until the winner's last flit is accepted downstream. Re-arbitrates in the release cycle, so back-to-back packets see no bubble.

## Interface
- N, default 5: number of requesters; legal range 1..16.
- IDX_W, default max(1, $clog2(N)): width of the grant index; derived, never overridden.

- clk  in  1  single clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- i_request  in  N  per-requester packet pending; once granted, held high through its last flit.
- i_last  in  N  per-requester current flit is the packet tail.
- i_ack  in  1  downstream accepted the granted requester's flit this cycle.
- o_grant  out  N  registered one-hot grant; all-zero when idle.
- o_grant_idx  out  IDX_W  registered binary index of o_grant; 0 when idle.
- o_busy  out  1  registered; high while a grant is held.

## Operation
- Reset values:
  - o_grant = 0, o_grant_idx = 0, o_busy = 0.
  - state = ARB_IDLE.
  - last-winner pointer = N-1, so index 0 has first priority after reset.
- Priority mask = bits strictly above the last-winner index.
- Winner selection:
  - masked = i_request & mask.
  - If masked is nonzero, the winner is the lowest set bit of masked.
  - Otherwise the winner is the lowest set bit of i_request.
- State ARB_IDLE:
  - If |i_request: register the winner into o_grant/o_grant_idx, update the pointer to the winner, set o_busy, go to ARB_BUSY.
  - Otherwise stay in ARB_IDLE.
- State ARB_BUSY:
  - Grant is held while !(i_ack && i_last[o_grant_idx]).
  - Release cycle (i_ack && i_last[granted]): arbitrate in the same cycle over the current i_request, using the mask derived from the current winner.
    - Requests present: load the new winner and stay in ARB_BUSY.
    - No requests: clear o_grant/o_busy and go to ARB_IDLE.
  - The releasing requester may win again only if no other requester is pending.
- i_ack with i_last low: no state change.
- i_ack in ARB_IDLE: ignored.
- i_last bits of non-granted requesters: ignored.
- Protocol violation: granted requester drops i_request before its tail is acked.
  - Arbiter keeps the grant.
  - Bench flags it with an assertion.
- N=1: grant = request, index always 0, lock/release rules unchanged.

## Timing
- Grant latency: request seen in ARB_IDLE at cycle t → o_grant valid at t+1.
- Handover: tail acked at cycle t → next winner's o_grant valid at t+1, zero idle cycles.
- Single-flit packet: i_last=1 and i_ack=1 on the first granted cycle → grant lasts exactly 1 cycle.
- Reset asserted mid-packet:
  - All outputs clear immediately (asynchronous).
  - Pointer returns to N-1.
  - First arbitration happens the first clock edge after deassertion.
- Timing paths:
  - Combinational path: i_request/i_last/i_ack → next-state logic only.
  - No combinational path from any input to any output.

## Structure
- Package noc_arb_pkg:
  - arb_state_e {ARB_IDLE, ARB_BUSY}.
  - Constant function idx_w(n) returning max(1, $clog2(n)).
  - Function onehot_to_idx for the one-hot → binary encode.
- Sub-module noc_prio_onehot #(WIDTH): combinational lowest-index-first one-hot picker, all-zero input → all-zero output.
  - Instantiated twice: once on the masked request vector, once on the unmasked one.
- Top holds the state register, pointer and output registers.

## Test plan
- Reset, then i_request=5'b10100 → cycle+1 o_grant=5'b00100, o_grant_idx=2, o_busy=1.
- All 5 requesting, single-flit packets (i_last=all-ones, i_ack=1 every cycle) → grants 0,1,2,3,4,0 on consecutive cycles, no gaps.
- Requester 3 holds a 4-flit packet with i_ack toggling 1,0,1,1,1 → grant stays 5'b01000 for 5 cycles despite requester 1 pending; requester 1 granted the cycle after the tail ack.
- Winner 4 releases while only requester 4 still requests → regranted idx 4 (wrap-around); if requester 0 also requests → idx 0 wins.
- rst_n pulsed low mid-packet on idx 2 → outputs 0 immediately; after release with i_request=5'b00110 → idx 1 granted first.
- N=1 instance: request held 3 flits → o_grant=1 throughout; drops to 0 the cycle after the tail ack when the request is deasserted.
